// File: rtl/trena_pkg.sv
// Shared types, ASCII constants and helpers for the tape-measure UART transmitter.
package trena_pkg;

  localparam int unsigned CHAR_W = 7;
  localparam int unsigned BCD_W  = 4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_DATA   = 4'd2,
    ST_PARITY = 4'd3,
    ST_STOP   = 4'd4,
    ST_NEXT   = 4'd5,
    ST_DONE   = 4'd6
  } estado_t;

  localparam logic [CHAR_W-1:0] ASCII_HASH       = 7'h23;
  localparam logic [CHAR_W-1:0] ASCII_QMARK      = 7'h3F;
  localparam logic [CHAR_W-1:0] ASCII_CR         = 7'h0D;
  localparam logic [CHAR_W-1:0] ASCII_LF         = 7'h0A;
  localparam logic [2:0]        ASCII_DIGIT_BASE = 3'b011;

  // Non-BCD digits are reported as '?' so a corrupt reading is visible on the terminal.
  function automatic logic [CHAR_W-1:0] bcd_to_ascii(input logic [BCD_W-1:0] d);
    return (d > 4'd9) ? ASCII_QMARK : {ASCII_DIGIT_BASE, d};
  endfunction

  function automatic logic parity7(input logic [CHAR_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/contador_baud.sv
// Bit-time counter: counts 0..DIV-1 and flags the last cycle of each bit.
module contador_baud #(
  parameter int unsigned DIV = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  assign tick_c = (count_q == CNT_W'(DIV - 1));

  always_comb begin
    count_d = count_q + 1'b1;
    if (clr || tick_c) count_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/trena_tx_medida.sv
// Sends a latched N-digit BCD distance as an ASCII UART frame (7 data bits + parity).
// Define TRENA_TX_CRLF_EN to append CR LF after the terminator.
module trena_tx_medida
  import trena_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 3,
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned PARITY_ODD = 1,
  parameter int unsigned STOP_BITS  = 1,
  parameter logic [6:0]  TERMINATOR = 7'h23
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enviar,
  input  logic [4*N_DIGITS-1:0] medida,
  output logic                  saida_serial,
  output logic                  ocupado,
  output logic                  pronto,
  output logic [3:0]            db_estado
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned MED_W = BCD_W * N_DIGITS;
`ifdef TRENA_TX_CRLF_EN
  localparam int unsigned N_CHARS = N_DIGITS + 3;
`else
  localparam int unsigned N_CHARS = N_DIGITS + 1;
`endif
  localparam int unsigned IDX_W = $clog2(N_CHARS);

  estado_t             state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [2:0]          bit_q, bit_d;
  logic [MED_W-1:0]    shadow_q, shadow_d;
  logic [CHAR_W-1:0]   char_q, char_d;
  logic [CHAR_W-1:0]   sh_q, sh_d;
  logic                saida_q, saida_d;
  logic                ocupado_q, ocupado_d;
  logic                pronto_q, pronto_d;
  logic                clr_c;
  logic                tick_c;

  // Character idx of the frame: digits MSB first, then the terminator (and CR LF).
  function automatic logic [CHAR_W-1:0] char_at(input logic [MED_W-1:0] m,
                                                input logic [IDX_W-1:0] idx);
    logic [CHAR_W-1:0] c;
    c = TERMINATOR;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(N_DIGITS - 1 - k)) c = bcd_to_ascii(m[BCD_W*k +: BCD_W]);
    end
`ifdef TRENA_TX_CRLF_EN
    if (idx == IDX_W'(N_DIGITS + 1)) c = ASCII_CR;
    if (idx == IDX_W'(N_DIGITS + 2)) c = ASCII_LF;
`endif
    return c;
  endfunction

  contador_baud #(.DIV(DIV)) u_baud (
    .clock  (clock),
    .reset  (reset),
    .clr    (clr_c),
    .tick_c (tick_c)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    bit_d    = bit_q;
    shadow_d = shadow_q;
    char_d   = char_q;
    sh_d     = sh_q;
    clr_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enviar) begin
          state_d  = ST_START;
          shadow_d = medida;
          idx_d    = '0;
          bit_d    = '0;
          char_d   = char_at(medida, '0);
          clr_c    = 1'b1;
        end
      end
      ST_START: begin
        if (tick_c) begin
          state_d = ST_DATA;
          sh_d    = char_q;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (bit_q == 3'd6) begin
            state_d = ST_PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[CHAR_W-1:1]};
          end
        end
      end
      ST_PARITY: begin
        if (tick_c) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        // The NEXT decision happens here so characters follow back to back.
        if (tick_c) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            if (idx_q == IDX_W'(N_CHARS - 1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_START;
              idx_d   = idx_q + 1'b1;
              char_d  = char_at(shadow_q, idx_q + 1'b1);
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    case (state_d)
      ST_START:  saida_d = 1'b0;
      ST_DATA:   saida_d = sh_d[0];
      ST_PARITY: saida_d = parity7(char_q, PARITY_ODD != 0);
      default:   saida_d = 1'b1;
    endcase
    ocupado_d = (state_d == ST_START) || (state_d == ST_DATA) ||
                (state_d == ST_PARITY) || (state_d == ST_STOP);
    pronto_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      bit_q     <= '0;
      shadow_q  <= '0;
      char_q    <= '0;
      sh_q      <= '0;
      saida_q   <= 1'b1;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bit_q     <= bit_d;
      shadow_q  <= shadow_d;
      char_q    <= char_d;
      sh_q      <= sh_d;
      saida_q   <= saida_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign saida_serial = saida_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign db_estado    = state_q;

endmodule

// File: tb/tb_trena_tx_medida.sv
// Bench for trena_tx_medida: odd/1-stop and even/2-stop instances at DIV=10.
module tb_trena_tx_medida;

  localparam int DIV = 10;
  localparam int ND  = 3;
`ifdef TRENA_TX_CRLF_EN
  localparam int NCH = ND + 3;
`else
  localparam int NCH = ND + 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enviar_a, enviar_b;
  logic [11:0] medida_a, medida_b;
  logic        saida_a, ocup_a, pronto_a;
  logic        saida_b, ocup_b, pronto_b;
  logic [3:0]  db_a, db_b;

  always #5 clock = ~clock;

  trena_tx_medida #(.N_DIGITS(3), .CLK_FREQ(1000), .BAUD(100), .PARITY_ODD(1),
                    .STOP_BITS(1), .TERMINATOR(7'h23)) dut_a (
    .clock(clock), .reset(reset), .enviar(enviar_a), .medida(medida_a),
    .saida_serial(saida_a), .ocupado(ocup_a), .pronto(pronto_a), .db_estado(db_a));

  trena_tx_medida #(.N_DIGITS(3), .CLK_FREQ(1000), .BAUD(100), .PARITY_ODD(0),
                    .STOP_BITS(2), .TERMINATOR(7'h23)) dut_b (
    .clock(clock), .reset(reset), .enviar(enviar_b), .medida(medida_b),
    .saida_serial(saida_b), .ocupado(ocup_b), .pronto(pronto_b), .db_estado(db_b));

  int n_assert = 0;
  int n_fail   = 0;

  bit ln_q[$];
  bit oc_q[$];
  bit pr_q[$];
  int st_q[$];
  bit exp_bits[$];

  typedef struct {
    logic [11:0] m;
    bit          inst;
    logic [27:0] chars;
    logic [3:0]  par;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference line waveform, one entry per bit time, built straight from the frame format.
  function automatic void build(input logic [11:0] m, input bit odd, input int stops);
    logic [6:0] chs[$];
    exp_bits.delete();
    for (int i = 0; i < ND; i++) begin
      int d;
      d = int'((m >> (4 * (ND - 1 - i))) & 12'hF);
      chs.push_back(d > 9 ? 7'h3F : 7'(48 + d));
    end
    chs.push_back(7'h23);
`ifdef TRENA_TX_CRLF_EN
    chs.push_back(7'h0D);
    chs.push_back(7'h0A);
`endif
    foreach (chs[j]) begin
      int ones;
      ones = $countones(chs[j]);
      exp_bits.push_back(1'b0);
      for (int b = 0; b < 7; b++) exp_bits.push_back(chs[j][b]);
      exp_bits.push_back(odd ? (ones % 2 == 0) : (ones % 2 == 1));
      for (int s = 0; s < stops; s++) exp_bits.push_back(1'b1);
    end
  endfunction

  task automatic start_frame(input bit inst, input logic [11:0] m);
    @(negedge clock);
    if (inst) begin medida_b = m; enviar_b = 1'b1; end
    else      begin medida_a = m; enviar_a = 1'b1; end
    @(posedge clock);
  endtask

  task automatic capture(input bit inst, input int ncyc, input int drop_cyc,
                         input int c1, input logic [11:0] m1, input int c2, input logic [11:0] m2);
    ln_q.delete(); oc_q.delete(); pr_q.delete(); st_q.delete();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clock);
      ln_q.push_back(inst ? saida_b : saida_a);
      oc_q.push_back(inst ? ocup_b : ocup_a);
      pr_q.push_back(inst ? pronto_b : pronto_a);
      st_q.push_back(int'(inst ? db_b : db_a));
      if (cyc == drop_cyc) begin if (inst) enviar_b = 1'b0; else enviar_a = 1'b0; end
      if (cyc == c1) begin if (inst) medida_b = m1; else medida_a = m1; end
      if (cyc == c2) begin if (inst) medida_b = m2; else medida_a = m2; end
    end
  endtask

  function automatic int frame_len(input bit inst);
    return NCH * (9 + (inst ? 2 : 1)) * DIV;
  endfunction

  task automatic check_frame(input string name, input bit inst, input logic [11:0] m, input int off);
    int stops, bpc, L, bl, bo, bp, bs, pos, est;
    stops = inst ? 2 : 1;
    bpc   = 9 + stops;
    build(m, !inst, stops);
    L = exp_bits.size() * DIV;
    bl = 0; bo = 0; bp = 0; bs = 0;
    for (int cyc = 0; cyc <= L + 1; cyc++) begin
      pos = (cyc / DIV) % bpc;
      if (cyc == L)          est = 6;
      else if (cyc == L + 1) est = 0;
      else if (pos == 0)     est = 1;
      else if (pos <= 7)     est = 2;
      else if (pos == 8)     est = 3;
      else                   est = 4;
      if (ln_q[off+cyc] !== ((cyc < L) ? exp_bits[cyc/DIV] : 1'b1)) bl++;
      if (oc_q[off+cyc] !== (cyc < L)) bo++;
      if (pr_q[off+cyc] !== (cyc == L)) bp++;
      if (st_q[off+cyc] != est) bs++;
    end
    check({name, " length"}, 64'(L), 64'(frame_len(inst)));
    check({name, " line bad cycles"}, 64'(bl), 64'd0);
    check({name, " ocupado bad cycles"}, 64'(bo), 64'd0);
    check({name, " pronto bad cycles"}, 64'(bp), 64'd0);
    check({name, " db_estado bad cycles"}, 64'(bs), 64'd0);
  endtask

  // Mid-bit UART receive of the first four characters.
  task automatic decode(input string name, input bit inst, input int off,
                        input logic [27:0] chars, input logic [3:0] par);
    logic [27:0] got_c;
    logic [3:0]  got_p;
    logic [6:0]  ch;
    int bpc, base;
    bpc = 9 + (inst ? 2 : 1);
    got_c = '0; got_p = '0;
    for (int j = 0; j < 4; j++) begin
      base = off + j * bpc * DIV + DIV / 2;
      for (int b = 0; b < 7; b++) ch[b] = ln_q[base + (1 + b) * DIV];
      got_c = {got_c[20:0], ch};
      got_p = {got_p[2:0], ln_q[base + 8 * DIV]};
    end
    check({name, " chars"}, 64'(got_c), 64'(chars));
    check({name, " parity"}, 64'(got_p), 64'(par));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    logic [11:0] m;
    bit inst;
    int L;

    tbl[0] = '{12'h305, 1'b0, {7'h33, 7'h30, 7'h35, 7'h23}, 4'b1110};
    tbl[1] = '{12'h2A7, 1'b0, {7'h32, 7'h3F, 7'h37, 7'h23}, 4'b0100};
    tbl[2] = '{12'h999, 1'b0, {7'h39, 7'h39, 7'h39, 7'h23}, 4'b1110};
    tbl[3] = '{12'hF0B, 1'b0, {7'h3F, 7'h30, 7'h3F, 7'h23}, 4'b1110};
    tbl[4] = '{12'h000, 1'b1, {7'h30, 7'h30, 7'h30, 7'h23}, 4'b0001};

    reset = 1'b0; enviar_a = 1'b0; enviar_b = 1'b0; medida_a = '0; medida_b = '0;
    #12;
    check("reset saida", 64'(saida_a), 64'd1);
    check("reset ocupado", 64'(ocup_a), 64'd0);
    check("reset pronto", 64'(pronto_a), 64'd0);
    check("reset db_estado", 64'(db_a), 64'd0);
    check("reset saida_b", 64'(saida_b), 64'd1);
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);

    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      L = frame_len(tbl[i].inst);
      start_frame(tbl[i].inst, tbl[i].m);
      capture(tbl[i].inst, L + 2, 0, -1, '0, -1, '0);
      check_frame(nm, tbl[i].inst, tbl[i].m, 0);
      decode(nm, tbl[i].inst, 0, tbl[i].chars, tbl[i].par);
    end

    // enviar held through two frames; medida edits mid-frame must not leak in.
    L = frame_len(1'b0);
    start_frame(1'b0, 12'h305);
    capture(1'b0, 2 * L + 4, L + 2, 50, 12'h418, L + 50, 12'h926);
    check_frame("hold f1", 1'b0, 12'h305, 0);
    check_frame("hold f2", 1'b0, 12'h418, L + 2);
    repeat (3) @(negedge clock);

    // Asynchronous reset in the middle of a low data bit.
    start_frame(1'b0, 12'h305);
    @(negedge clock); enviar_a = 1'b0;
    repeat (125) @(posedge clock);
    #1;
    check("pre-reset line", 64'(saida_a), 64'd0);
    reset = 1'b0;
    #1;
    check("midreset saida", 64'(saida_a), 64'd1);
    check("midreset ocupado", 64'(ocup_a), 64'd0);
    check("midreset db_estado", 64'(db_a), 64'd0);
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    start_frame(1'b0, 12'h718);
    capture(1'b0, L + 2, 0, -1, '0, -1, '0);
    check_frame("after reset", 1'b0, 12'h718, 0);

    for (int r = 0; r < 6; r++) begin
      m    = 12'($urandom);
      inst = 1'($urandom_range(0, 1));
      L = frame_len(inst);
      start_frame(inst, m);
      capture(inst, L + 2, 0, -1, '0, -1, '0);
      check_frame($sformatf("rand%0d", r), inst, m, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/trena_tx_medida.md
Name: trena_tx_medida

Overview:
Parametrised transmitter for the digital tape-measure datapath. It latches an N-digit BCD distance and sends it over UART as an ASCII frame: digits MSB first, then a terminator character. It integrates its own character sequencer, baud generator and 7-bit parity serialiser, so the top-level control FSM only issues a start request and waits for done. It sits between the HC-SR04 interface output and the serial pin.

Parameters:
N_DIGITS, 3, number of BCD digits in medida (1..8)
CLK_FREQ, 50000000, clock frequency in Hz
BAUD, 115200, serial bit rate; DIV = CLK_FREQ/BAUD clocks per bit (integer division, DIV >= 2)
PARITY_ODD, 1, 1 = odd parity, 0 = even parity
STOP_BITS, 1, number of stop bits (1 or 2)
TERMINATOR, 7'h23, ASCII terminator sent after the digits ('#')

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enviar  in  1  start request, level-sampled in IDLE
medida  in  4*N_DIGITS  BCD distance; digit k is medida[4k+3:4k], digit N_DIGITS-1 is the most significant
saida_serial  out  1  UART line, idle high
ocupado  out  1  high from acceptance until the end of the last stop bit
pronto  out  1  one-cycle pulse when the frame completes
db_estado  out  4  current FSM state code, for debug

Behaviour:
- Reset (reset=0, async): FSM to IDLE; saida_serial=1; ocupado=0; pronto=0; db_estado=0; all counters cleared. Asserting reset mid-frame returns the line high immediately. No partial character resumes after reset.
- IDLE: on a rising edge with enviar=1, latch medida into a shadow register, set character index to 0, set ocupado=1, go to START. enviar is ignored while ocupado=1, so no queuing occurs.
- Character sequence: index 0..N_DIGITS-1 selects digit N_DIGITS-1-index. Digit d is sent as {3'b011, d[3:0]}. A digit >9 (non-BCD) is sent as '?' (7'h3F). After the digits, TERMINATOR is sent.
- Per character, with each bit lasting exactly DIV clocks:
  - START: line 0.
  - DATA: 7 bits, LSB first.
  - PARITY: for odd parity, the bit makes the total count of ones in data plus parity odd; even parity is the mirror.
  - STOP: line 1 for STOP_BITS bit times.
- States, with db_estado codes: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, NEXT=5, DONE=6.
- NEXT: zero-cycle decision, folded into the last STOP cycle. It increments the index and goes to START if characters remain, otherwise to DONE. There is no idle gap between characters.
- Latency: saida_serial falls on the clock edge that accepts enviar. Frame length is C*(9+STOP_BITS)*DIV clocks, where C = N_DIGITS+1 (plus 2 with the optional feature).
- DONE: lasts one cycle. pronto=1 and ocupado=0 in this cycle, then the FSM returns to IDLE. A new enviar is accepted in the cycle after DONE.
- Baud counter: counts 0..DIV-1 and wraps. It is cleared on acceptance, so each bit boundary is aligned to the acceptance edge.
- Changes to medida while busy have no effect on the frame in progress.

Optional Feature:
- Macro TRENA_TX_CRLF_EN.
- Defined: after TERMINATOR, the block also sends CR (7'h0D) then LF (7'h0A); C = N_DIGITS+3.
- Undefined: the frame ends at TERMINATOR, and the CR/LF logic and wider index counter are absent.

Decomposition:
- Package trena_pkg holds:
  - FSM state encoding (values above).
  - ASCII constants: ASCII_HASH 7'h23, ASCII_QMARK 7'h3F, ASCII_CR, ASCII_LF, ASCII_DIGIT_BASE 3'b011.
  - Function bcd_to_ascii (with the >9 rule).
  - Function parity7 (takes the mode).
- One sub-module: contador_baud. It is a DIV-modulus counter with synchronous clear and a one-cycle tick output at count DIV-1. The FSM and shift register stay in trena_tx_medida.

Test Plan:
- Setup: CLK_FREQ=1000, BAUD=100 (DIV=10), N_DIGITS=3, odd parity, 1 stop bit.
- medida=12'h305, enviar one cycle -> chars 0x33, 0x30, 0x35, 0x23 with parity bits 1, 1, 1, 0. Each bit is 10 clocks. pronto pulses at cycle 400 after acceptance; ocupado is high for cycles 0..399.
- medida=12'h2A7 -> middle character is 7'h3F '?' (parity 1); the other characters are '2', '7', '#'.
- enviar held high through a frame, medida changed mid-frame -> the first frame is unchanged. A second frame starts the cycle after the pronto pulse, using the medida value sampled at that edge.
- reset pulled low at cycle 125 of a frame -> saida_serial=1, ocupado=0 in the same cycle. After release, enviar starts a fresh frame beginning with the MSB digit.
- PARITY_ODD=0, STOP_BITS=2, medida=12'h000 -> '0' parity bit 0, stop high for 20 clocks, frame 4*11*10=440 clocks. With TRENA_TX_CRLF_EN defined -> 0x0D, 0x0A follow '#', frame 6*11*10=660 clocks.
